// File: rtl/axi4_lite_cmd_master_if.sv
// AXI4-lite bundle shared by the command master and whatever register slave it talks to.
// Only the signals a single-beat register access needs are carried.
interface ifc_axi4_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-lite initiator: one command in, one AXI read or write out,
// one response back. Write AW and W complete independently before B is awaited.
module axi4_lite_cmd_master #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    AXI_DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] AXI_BASE_ADDR  = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  ifc_axi4_lite.master                if_axi,
  input  logic                        i_cmd_valid,
  output logic                        o_cmd_ready,
  input  logic                        i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]       i_cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                        o_rsp_valid,
  input  logic                        i_rsp_ready,
  output logic                        o_rsp_write,
  output logic [AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                  o_rsp_resp,
  output logic                        o_busy
);

  localparam logic [1:0] RESP_OKAY = 2'b00;

  if (!(AXI_DATA_WIDTH == 32 || AXI_DATA_WIDTH == 64)) begin : g_bad_data_width
    $error("axi4_lite_cmd_master: AXI_DATA_WIDTH must be 32 or 64");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic aw_done;
  logic w_done;
  logic aw_done_nxt;
  logic w_done_nxt;

  logic cmd_ready_c;
  logic awvalid_c;
  logic wvalid_c;
  logic bready_c;
  logic arvalid_c;
  logic rready_c;
  logic rsp_valid_c;

  logic                        write_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]                  resp_q;

  logic cmd_accept;
  logic b_hs;
  logic r_hs;

  assign cmd_accept = cmd_ready_c && i_cmd_valid;
  assign b_hs       = bready_c && if_axi.bvalid;
  assign r_hs       = rready_c && if_axi.rvalid;

  always_comb begin
    state_nxt   = state;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;
    cmd_ready_c = 1'b0;
    awvalid_c   = 1'b0;
    wvalid_c    = 1'b0;
    bready_c    = 1'b0;
    arvalid_c   = 1'b0;
    rready_c    = 1'b0;
    rsp_valid_c = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (i_cmd_valid) begin
          state_nxt   = i_cmd_write ? WR : RD_ADDR;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end

      // AW and W run independently; a handshake on either only retires that channel.
      WR: begin
        awvalid_c = !aw_done;
        wvalid_c  = !w_done;
        if (awvalid_c && if_axi.awready) aw_done_nxt = 1'b1;
        if (wvalid_c && if_axi.wready)   w_done_nxt  = 1'b1;
        if (aw_done_nxt && w_done_nxt) begin
          state_nxt   = WR_RESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end

      WR_RESP: begin
        bready_c = 1'b1;
        if (if_axi.bvalid) state_nxt = RSP;
      end

      RD_ADDR: begin
        arvalid_c = 1'b1;
        if (if_axi.arready) state_nxt = RD_DATA;
      end

      RD_DATA: begin
        rready_c = 1'b1;
        if (if_axi.rvalid) state_nxt = RSP;
      end

      RSP: begin
        rsp_valid_c = 1'b1;
        if (i_rsp_ready) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // A reset drops any in-flight transaction; the slave is expected to be reset alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      state   <= state_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      if (cmd_accept) begin
        write_q <= i_cmd_write;
        addr_q  <= AXI_BASE_ADDR + i_cmd_addr;
        wdata_q <= i_cmd_wdata;
        wstrb_q <= i_cmd_wstrb;
      end
      if (b_hs) begin
        resp_q  <= if_axi.bresp;
        rdata_q <= '0;
      end
      if (r_hs) begin
        resp_q  <= if_axi.rresp;
        rdata_q <= if_axi.rdata;
      end
    end
  end

  assign if_axi.awaddr  = addr_q;
  assign if_axi.awprot  = 3'b000;
  assign if_axi.awvalid = awvalid_c;
  assign if_axi.wdata   = wdata_q;
  assign if_axi.wstrb   = wstrb_q;
  assign if_axi.wvalid  = wvalid_c;
  assign if_axi.bready  = bready_c;
  assign if_axi.araddr  = addr_q;
  assign if_axi.arprot  = 3'b000;
  assign if_axi.arvalid = arvalid_c;
  assign if_axi.rready  = rready_c;

  assign o_cmd_ready = cmd_ready_c;
  assign o_rsp_valid = rsp_valid_c;
  assign o_rsp_write = write_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_resp  = resp_q;
  assign o_busy      = (state != IDLE);

endmodule
